// File: rtl/tft_frame_scheduler.sv
// Frame sequencer for the TFT SPI word path: emits the CASET/RASET/RAMWR window
// commands, then streams WIDTH*HEIGHT framebuffer pixels over a valid/ready link.
module tft_frame_scheduler #(
  parameter int WIDTH     = 128,
  parameter int HEIGHT    = 160,
  parameter int X_OFS     = 2,
  parameter int Y_OFS     = 1,
  parameter int ADDR_BITS = 15
) (
  input  logic                 MasterCLK,
  input  logic                 reset,
  input  logic                 init_done,
  input  logic                 frame_start,
  output logic                 pix_rd,
  output logic [ADDR_BITS-1:0] pix_addr,
  input  logic [15:0]          pix_data,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic [15:0]          word_data,
  output logic                 word_rs,
  output logic                 cs_n,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam logic [15:0] CMD_CASET = 16'h002A;
  localparam logic [15:0] CMD_RASET = 16'h002B;
  localparam logic [15:0] CMD_RAMWR = 16'h002C;
  localparam logic [15:0] XS_WORD   = 16'(X_OFS);
  localparam logic [15:0] XE_WORD   = 16'(X_OFS + WIDTH - 1);
  localparam logic [15:0] YS_WORD   = 16'(Y_OFS);
  localparam logic [15:0] YE_WORD   = 16'(Y_OFS + HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0] LAST_PIX = ADDR_BITS'(WIDTH * HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0] ONE_PIX  = ADDR_BITS'(1);

  // CAPT is the cycle the framebuffer drives pix_data; it is latched into the word register there.
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CASET = 4'd1,
    S_XS    = 4'd2,
    S_XE    = 4'd3,
    S_RASET = 4'd4,
    S_YS    = 4'd5,
    S_YE    = 4'd6,
    S_RAMWR = 4'd7,
    S_FETCH = 4'd8,
    S_CAPT  = 4'd9,
    S_PIX   = 4'd10,
    S_DONE  = 4'd11
  } state_t;

  state_t               state_r, nextState_s;
  logic [ADDR_BITS-1:0] pixCnt_r, pixCntNext_s;
  logic                 pixRd_r, pixRdNext_s;
  logic [ADDR_BITS-1:0] pixAddr_r, pixAddrNext_s;
  logic                 wordValid_r, wordValidNext_s;
  logic [15:0]          wordData_r, wordDataNext_s;
  logic                 wordRs_r, wordRsNext_s;
  logic                 csN_r, csNNext_s;
  logic                 busy_r, busyNext_s;
  logic                 frameDone_r, frameDoneNext_s;
  logic                 overrun_r, overrunNext_s;
  logic                 xfer_s;

  assign xfer_s     = wordValid_r & word_ready;
  assign pix_rd     = pixRd_r;
  assign pix_addr   = pixAddr_r;
  assign word_valid = wordValid_r;
  assign word_data  = wordData_r;
  assign word_rs    = wordRs_r;
  assign cs_n       = csN_r;
  assign busy       = busy_r;
  assign frame_done = frameDone_r;
  assign overrun    = overrun_r;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    nextState_s     = state_r;
    pixCntNext_s    = pixCnt_r;
    pixRdNext_s     = 1'b0;
    pixAddrNext_s   = pixAddr_r;
    wordValidNext_s = wordValid_r;
    wordDataNext_s  = wordData_r;
    wordRsNext_s    = wordRs_r;
    csNNext_s       = csN_r;
    busyNext_s      = busy_r;
    frameDoneNext_s = 1'b0;
    // Any request outside IDLE (DONE included) is dropped and remembered.
    overrunNext_s   = overrun_r | (frame_start & (state_r != S_IDLE));

    case (state_r)
      S_IDLE: begin
        if (frame_start && init_done) begin
          nextState_s     = S_CASET;
          wordValidNext_s = 1'b1;
          wordDataNext_s  = CMD_CASET;
          wordRsNext_s    = 1'b0;
          csNNext_s       = 1'b0;
          busyNext_s      = 1'b1;
          pixCntNext_s    = '0;
        end else begin
          nextState_s = S_IDLE;
        end
      end
      S_CASET: begin
        if (xfer_s) begin
          nextState_s    = S_XS;
          wordDataNext_s = XS_WORD;
          wordRsNext_s   = 1'b1;
        end else begin
          nextState_s = S_CASET;
        end
      end
      S_XS: begin
        if (xfer_s) begin
          nextState_s    = S_XE;
          wordDataNext_s = XE_WORD;
          wordRsNext_s   = 1'b1;
        end else begin
          nextState_s = S_XS;
        end
      end
      S_XE: begin
        if (xfer_s) begin
          nextState_s    = S_RASET;
          wordDataNext_s = CMD_RASET;
          wordRsNext_s   = 1'b0;
        end else begin
          nextState_s = S_XE;
        end
      end
      S_RASET: begin
        if (xfer_s) begin
          nextState_s    = S_YS;
          wordDataNext_s = YS_WORD;
          wordRsNext_s   = 1'b1;
        end else begin
          nextState_s = S_RASET;
        end
      end
      S_YS: begin
        if (xfer_s) begin
          nextState_s    = S_YE;
          wordDataNext_s = YE_WORD;
          wordRsNext_s   = 1'b1;
        end else begin
          nextState_s = S_YS;
        end
      end
      S_YE: begin
        if (xfer_s) begin
          nextState_s    = S_RAMWR;
          wordDataNext_s = CMD_RAMWR;
          wordRsNext_s   = 1'b0;
        end else begin
          nextState_s = S_YE;
        end
      end
      S_RAMWR: begin
        if (xfer_s) begin
          nextState_s     = S_FETCH;
          wordValidNext_s = 1'b0;
          pixRdNext_s     = 1'b1;
          pixAddrNext_s   = pixCnt_r;
        end else begin
          nextState_s = S_RAMWR;
        end
      end
      S_FETCH: begin
        nextState_s = S_CAPT;
      end
      S_CAPT: begin
        nextState_s     = S_PIX;
        wordValidNext_s = 1'b1;
        wordDataNext_s  = pix_data;
        wordRsNext_s    = 1'b1;
      end
      S_PIX: begin
        if (xfer_s) begin
          wordValidNext_s = 1'b0;
          if (pixCnt_r == LAST_PIX) begin
            nextState_s     = S_DONE;
            frameDoneNext_s = 1'b1;
            csNNext_s       = 1'b1;
            busyNext_s      = 1'b0;
            pixCntNext_s    = '0;
          end else begin
            nextState_s   = S_FETCH;
            pixCntNext_s  = pixCnt_r + ONE_PIX;
            pixRdNext_s   = 1'b1;
            pixAddrNext_s = pixCnt_r + ONE_PIX;
          end
        end else begin
          nextState_s = S_PIX;
        end
      end
      S_DONE: begin
        nextState_s  = S_IDLE;
        pixCntNext_s = '0;
      end
      default: begin
        nextState_s     = S_IDLE;
        wordValidNext_s = 1'b0;
        csNNext_s       = 1'b1;
        busyNext_s      = 1'b0;
        pixCntNext_s    = '0;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge MasterCLK) begin
    if (reset) begin
      state_r     <= S_IDLE;
      pixCnt_r    <= '0;
      pixRd_r     <= 1'b0;
      pixAddr_r   <= '0;
      wordValid_r <= 1'b0;
      wordData_r  <= 16'h0000;
      wordRs_r    <= 1'b0;
      csN_r       <= 1'b1;
      busy_r      <= 1'b0;
      frameDone_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= nextState_s;
      pixCnt_r    <= pixCntNext_s;
      pixRd_r     <= pixRdNext_s;
      pixAddr_r   <= pixAddrNext_s;
      wordValid_r <= wordValidNext_s;
      wordData_r  <= wordDataNext_s;
      wordRs_r    <= wordRsNext_s;
      csN_r       <= csNNext_s;
      busy_r      <= busyNext_s;
      frameDone_r <= frameDoneNext_s;
      overrun_r   <= overrunNext_s;
    end
  end

endmodule

// File: tb/tb_tft_frame_scheduler.sv
// Bench: a 4x2 instance under varied handshakes/gating/reset and a default-size
// instance streaming a full frame, both checked against a frame-level word model.
module tb_tft_frame_scheduler;
  localparam int AB = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst      [2];
  logic          initDone [2];
  logic          fs       [2];
  logic          rdy      [2];
  logic          pixRd    [2];
  logic [AB-1:0] pixAddr  [2];
  logic [15:0]   pixData  [2] = '{16'h0000, 16'h0000};
  logic          wv       [2];
  logic [15:0]   wd       [2];
  logic          wrs      [2];
  logic          csn      [2];
  logic          busy     [2];
  logic          fdone    [2];
  logic          ovr      [2];

  logic [15:0] fbSmall [8];
  int          rdyMode = 0;
  logic        stopRdy = 1'b0;
  int          checks  = 0;
  int          errors  = 0;

  // Frame-level model state, one slot per instance.
  logic          started   [2] = '{1'b0, 1'b0};
  logic          mBusy     [2] = '{1'b0, 1'b0};
  logic          mDone     [2] = '{1'b0, 1'b0};
  logic          mOvr      [2] = '{1'b0, 1'b0};
  logic          mFirst    [2] = '{1'b0, 1'b0};
  logic          mAfterRst [2] = '{1'b0, 1'b0};
  logic          stallPrev [2] = '{1'b0, 1'b0};
  logic [15:0]   prevData  [2] = '{16'h0000, 16'h0000};
  logic          prevRs    [2] = '{1'b0, 1'b0};
  logic [AB-1:0] prevAddr  [2] = '{15'd0, 15'd0};
  int            mIdx      [2] = '{0, 0};
  int            doneCnt   [2] = '{0, 0};
  int            pixWords  [2] = '{0, 0};
  logic [15:0]   lastPix   [2] = '{16'h0000, 16'h0000};
  logic [15:0]   seenXE    [2] = '{16'h0000, 16'h0000};
  logic [15:0]   seenYE    [2] = '{16'h0000, 16'h0000};

  tft_frame_scheduler #(.WIDTH(4), .HEIGHT(2), .X_OFS(2), .Y_OFS(1), .ADDR_BITS(AB)) dutSmall (
    .MasterCLK(clk), .reset(rst[0]), .init_done(initDone[0]), .frame_start(fs[0]),
    .pix_rd(pixRd[0]), .pix_addr(pixAddr[0]), .pix_data(pixData[0]),
    .word_valid(wv[0]), .word_ready(rdy[0]), .word_data(wd[0]), .word_rs(wrs[0]),
    .cs_n(csn[0]), .busy(busy[0]), .frame_done(fdone[0]), .overrun(ovr[0])
  );

  tft_frame_scheduler dutBig (
    .MasterCLK(clk), .reset(rst[1]), .init_done(initDone[1]), .frame_start(fs[1]),
    .pix_rd(pixRd[1]), .pix_addr(pixAddr[1]), .pix_data(pixData[1]),
    .word_valid(wv[1]), .word_ready(rdy[1]), .word_data(wd[1]), .word_rs(wrs[1]),
    .cs_n(csn[1]), .busy(busy[1]), .frame_done(fdone[1]), .overrun(ovr[1])
  );

  // Framebuffers with one-cycle read latency; the large one holds pix = addr.
  always @(posedge clk) begin
    if (pixRd[0]) pixData[0] <= fbSmall[pixAddr[0][2:0]];
    if (pixRd[1]) pixData[1] <= {1'b0, pixAddr[1]};
  end

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h, expected %0h", d, nm, act, exp);
    end
  endtask

  function automatic int frameLen(input int d);
    return (d == 0) ? 7 + 4 * 2 : 7 + 128 * 160;
  endfunction

  // Word i of a frame as {rs, data}: seven window words, then pixels in address order.
  function automatic logic [16:0] expWord(input int d, input int i);
    int w;
    int h;
    w = (d == 0) ? 4 : 128;
    h = (d == 0) ? 2 : 160;
    case (i)
      0:       expWord = {1'b0, 16'h002A};
      1:       expWord = {1'b1, 16'(2)};
      2:       expWord = {1'b1, 16'(2 + w - 1)};
      3:       expWord = {1'b0, 16'h002B};
      4:       expWord = {1'b1, 16'(1)};
      5:       expWord = {1'b1, 16'(1 + h - 1)};
      6:       expWord = {1'b0, 16'h002C};
      default: expWord = (d == 0) ? {1'b1, fbSmall[3'(i - 7)]} : {1'b1, 16'(i - 7)};
    endcase
  endfunction

  // Compare process: check outputs of the cycle, then advance the model with its inputs.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic curBusy;
        logic curDone;
        logic nextDone;
        curBusy  = mBusy[d];
        curDone  = mDone[d];
        nextDone = 1'b0;
        if (started[d]) begin
          chk(d, "busy", busy[d], curBusy);
          chk(d, "cs_n", csn[d], !curBusy);
          chk(d, "frame_done", fdone[d], curDone);
          chk(d, "overrun", ovr[d], mOvr[d]);
          if (!curBusy) chk(d, "valid_outside_frame", wv[d], 1'b0);
          if (mFirst[d]) chk(d, "first_word_latency", wv[d], 1'b1);
          if (mAfterRst[d]) begin
            chk(d, "rst_word_valid", wv[d], 1'b0);
            chk(d, "rst_word_data", wd[d], 16'h0000);
            chk(d, "rst_word_rs", wrs[d], 1'b0);
            chk(d, "rst_pix_rd", pixRd[d], 1'b0);
            chk(d, "rst_pix_addr", pixAddr[d], 15'd0);
          end else if (!pixRd[d]) begin
            chk(d, "pix_addr_hold", pixAddr[d], prevAddr[d]);
          end
          if (stallPrev[d]) chk(d, "stall_hold", {wv[d], wrs[d], wd[d]}, {1'b1, prevRs[d], prevData[d]});
        end
        if (rst[d]) begin
          started[d]   = 1'b1;
          mBusy[d]     = 1'b0;
          mDone[d]     = 1'b0;
          mOvr[d]      = 1'b0;
          mIdx[d]      = 0;
          mFirst[d]    = 1'b0;
          mAfterRst[d] = 1'b1;
          stallPrev[d] = 1'b0;
        end else if (started[d]) begin
          mAfterRst[d] = 1'b0;
          mFirst[d]    = 1'b0;
          if (wv[d] && rdy[d]) begin
            if (curBusy && mIdx[d] < frameLen(d)) begin
              chk(d, $sformatf("word%0d", mIdx[d]), {wrs[d], wd[d]}, expWord(d, mIdx[d]));
              if (mIdx[d] == 2) seenXE[d] = wd[d];
              if (mIdx[d] == 5) seenYE[d] = wd[d];
              if (mIdx[d] >= 7) begin
                pixWords[d]++;
                lastPix[d] = wd[d];
              end
              mIdx[d]++;
              if (mIdx[d] == frameLen(d)) begin
                mBusy[d] = 1'b0;
                nextDone = 1'b1;
              end
            end else begin
              checks++;
              errors++;
              $display("FAIL dut%0d unexpected_word: got %0h, expected no transfer", d, {wrs[d], wd[d]});
            end
          end
          if (fdone[d]) doneCnt[d]++;
          if (fs[d]) begin
            if (curBusy || curDone) begin
              mOvr[d] = 1'b1;
            end else if (initDone[d]) begin
              mBusy[d]  = 1'b1;
              mIdx[d]   = 0;
              mFirst[d] = 1'b1;
            end
          end
          mDone[d]     = nextDone;
          stallPrev[d] = wv[d] && !rdy[d];
          prevData[d]  = wd[d];
          prevRs[d]    = wrs[d];
        end
        prevAddr[d] = pixAddr[d];
      end
    end
  end

  task automatic pulse(input int d);
    @(posedge clk); #1 fs[d] = 1'b1;
    @(posedge clk); #1 fs[d] = 1'b0;
  endtask

  task automatic doReset(input int d);
    @(posedge clk); #1 rst[d] = 1'b1;
    @(posedge clk); #1 rst[d] = 1'b0;
  endtask

  task automatic runFrame(input int d, input int budget, input int npix);
    int dBefore;
    int pBefore;
    dBefore = doneCnt[d];
    pBefore = pixWords[d];
    pulse(d);
    for (int c = 0; c < budget && doneCnt[d] == dBefore; c++) @(posedge clk);
    chk(d, "frames_completed", doneCnt[d] - dBefore, 1);
    chk(d, "pixels_in_frame", pixWords[d] - pBefore, npix);
  endtask

  task automatic readyDrv();
    int ph;
    ph = 0;
    while (!stopRdy) begin
      @(posedge clk); #1;
      case (rdyMode)
        0:       rdy[0] = 1'b1;
        1:       rdy[0] = (ph % 4 == 0) || (ph % 4 == 3);
        default: rdy[0] = 1'($urandom_range(0, 1));
      endcase
      ph++;
    end
  endtask

  task automatic bigRun();
    runFrame(1, 70000, 20480);
    chk(1, "xe_word", seenXE[1], 16'h0081);
    chk(1, "ye_word", seenYE[1], 16'h00A0);
    chk(1, "last_pixel", lastPix[1], 16'h4FFF);
  endtask

  task automatic smallRun();
    int p0;
    int d0;
    int c;
    // Plain, 1-0-0-1 backpressure, then random backpressure.
    rdyMode = 0;
    runFrame(0, 500, 8);
    rdyMode = 1;
    runFrame(0, 1000, 8);
    rdyMode = 2;
    repeat (3) runFrame(0, 2000, 8);
    rdyMode = 0;
    // Gating on init_done.
    @(posedge clk); #1 initDone[0] = 1'b0;
    pulse(0);
    repeat (6) @(posedge clk);
    #2;
    chk(0, "gated_busy", busy[0], 1'b0);
    chk(0, "gated_valid", wv[0], 1'b0);
    @(posedge clk); #1 initDone[0] = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk(0, "init_only_busy", busy[0], 1'b0);
    runFrame(0, 500, 8);
    // Second request during the pixel phase.
    p0 = pixWords[0];
    d0 = doneCnt[0];
    pulse(0);
    for (c = 0; c < 500 && pixWords[0] - p0 < 2; c++) @(posedge clk);
    pulse(0);
    for (c = 0; c < 500 && doneCnt[0] == d0; c++) @(posedge clk);
    repeat (20) @(posedge clk);
    #2;
    chk(0, "overrun_sticky", ovr[0], 1'b1);
    chk(0, "overrun_frames", doneCnt[0] - d0, 1);
    chk(0, "overrun_pixels", pixWords[0] - p0, 8);
    chk(0, "overrun_idle", busy[0], 1'b0);
    // Request landing in the DONE cycle.
    doReset(0);
    p0 = pixWords[0];
    d0 = doneCnt[0];
    pulse(0);
    c = 0;
    do begin
      @(posedge clk); #2;
      c++;
    end while (c < 500 && pixWords[0] - p0 != 8);
    chk(0, "done_cycle_reached", fdone[0], 1'b1);
    fs[0] = 1'b1;
    @(posedge clk); #1 fs[0] = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk(0, "done_overrun", ovr[0], 1'b1);
    chk(0, "done_frames", doneCnt[0] - d0, 1);
    // Reset while pixel 3 is presented.
    doReset(0);
    p0 = pixWords[0];
    pulse(0);
    c = 0;
    do begin
      @(posedge clk); #2;
      c++;
    end while (c < 500 && !(pixWords[0] - p0 == 3 && wv[0]));
    chk(0, "pixel3_presented", wv[0], 1'b1);
    rst[0] = 1'b1;
    @(posedge clk); #1 rst[0] = 1'b0;
    @(negedge clk);
    chk(0, "abort_valid", wv[0], 1'b0);
    chk(0, "abort_cs_n", csn[0], 1'b1);
    runFrame(0, 500, 8);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) fbSmall[i] = 16'($urandom);
    for (int d = 0; d < 2; d++) begin
      rst[d]      = 1'b1;
      fs[d]       = 1'b0;
      initDone[d] = 1'b1;
      rdy[d]      = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    fork
      bigRun();
      begin
        smallRun();
        stopRdy = 1'b1;
      end
      readyDrv();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tft_frame_scheduler.md
Name: tft_frame_scheduler

Overview:
- Controller that sequences the TFT SPI word datapath after panel initialization completes.
- Per frame, it issues the window-address command sequence (CASET, RASET, RAMWR) and then streams WIDTH*HEIGHT pixel words fetched from the framebuffer.
- Sits between the framebuffer (synchronous read, 1-cycle latency) and the SPI word serializer, which uses a valid/ready handshake.
- Owns the RS and CS lines for the duration of a frame.

Parameters:
- WIDTH, 128, visible columns per frame.
- HEIGHT, 160, visible rows per frame.
- X_OFS, 2, panel column offset added to the CASET start/end values.
- Y_OFS, 1, panel row offset added to the RASET start/end values.
- ADDR_BITS, 15, framebuffer address width; must satisfy 2^ADDR_BITS >= WIDTH*HEIGHT.

Ports:
- MasterCLK  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- init_done  input  1  high once panel init sequence has finished; level.
- frame_start  input  1  one-cycle request to send a frame.
- pix_rd  output  1  framebuffer read strobe.
- pix_addr  output  ADDR_BITS  framebuffer read address, row-major (row*WIDTH+col).
- pix_data  input  16  RGB565 pixel, valid the cycle after pix_rd.
- word_valid  output  1  word_data/word_rs are valid.
- word_ready  input  1  serializer accepts the word this cycle.
- word_data  output  16  command or data word.
- word_rs  output  1  0 = command, 1 = data.
- cs_n  output  1  panel chip select, active low.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse after the last pixel is accepted.
- overrun  output  1  sticky flag: frame_start arrived while busy; cleared only by reset.

Behaviour:
- Reset values: state IDLE; word_valid=0, word_data=0, word_rs=0, cs_n=1, pix_rd=0, pix_addr=0, busy=0, frame_done=0, overrun=0.
- Reset asserted mid-frame aborts immediately: the word in flight is dropped and the frame is not resumed.
- Handshake:
  - A transfer occurs on a cycle where word_valid && word_ready.
  - While word_valid=1 and word_ready=0, word_data and word_rs hold stable.
  - word_valid never drops without a transfer, except on reset.
- States and emitted words (each state presents one word and advances on transfer):
  - CASET: 0x002A, rs 0.
  - XS: X_OFS, rs 1.
  - XE: X_OFS+WIDTH-1, rs 1.
  - RASET: 0x002B, rs 0.
  - YS: Y_OFS, rs 1.
  - YE: Y_OFS+HEIGHT-1, rs 1.
  - RAMWR: 0x002C, rs 0.
  - Then FETCH/PIX loop, then DONE.
- All command/parameter words are 16 bits; values are zero-extended.
- IDLE: if frame_start && init_done, go to CASET next cycle, with busy=1, cs_n=0 and word_valid=1 on that cycle. Latency from frame_start to first word_valid is 1 cycle.
- frame_start while init_done=0 is ignored; no flag is set.
- FETCH: for one cycle, pix_rd=1 and pix_addr=pixel counter; word_valid=0. Next cycle, pix_data is captured into the word register and the state goes to PIX.
- PIX: presents the captured pixel with word_valid=1, word_rs=1. On transfer:
  - If the counter equals WIDTH*HEIGHT-1, go to DONE.
  - Otherwise increment the counter and go to FETCH.
- Throughput is at most 1 pixel per 2 cycles; this is acceptable because the SPI is much slower.
- DONE: one cycle with frame_done=1, cs_n=1, busy=0; the counter clears to 0; return to IDLE.
  - A frame_start in DONE is treated as busy (sets overrun and is dropped).
- busy=1 from CASET through the last PIX state.
- frame_start while busy sets overrun=1; the request is discarded, not queued.
- A new frame always restarts at pixel 0 (no partial-frame resume).
- init_done falling mid-frame is ignored; the frame completes.
- pix_addr holds its last value when pix_rd=0.

Test Plan:
- Command sequence: WIDTH=4, HEIGHT=2, X_OFS=2, Y_OFS=1, word_ready tied 1, init_done=1, frame_start pulse.
  - Expected words (rs): 002A(0), 0002(1), 0005(1), 002B(0), 0001(1), 0002(1), 002C(0), then pixels at addresses 0..7 in order (rs 1).
  - frame_done pulses once; cs_n is low for the whole sequence.
- Backpressure: same config with word_ready toggling 1,0,0,1 repeatedly.
  - word_data/word_rs are stable during every stall cycle; the word sequence is identical to the first test; no word is duplicated or lost.
- Gating: frame_start with init_done=0 gives no word_valid and busy=0. Raising init_done alone starts nothing; a later frame_start starts a frame.
- Overrun: a second frame_start during the pixel phase sets overrun=1, which stays set. The current frame completes with exactly 8 pixels, and no second frame follows.
- Reset mid-stream: assert reset during pixel 3 with word_valid=1.
  - Next cycle, all outputs are at reset values.
  - A subsequent frame_start produces 002A first and pixels from address 0.
- Default size: WIDTH=128, HEIGHT=160, framebuffer preloaded with pix = addr[15:0].
  - Exactly 20480 pixel words are sent, the last being 0x4FFF.
  - XE=0x0081 and YE=0x00A0.
